// File: rtl/apb_regs.sv
// rtl/apb_regs.sv - APB register file with byte strobes; optional wait states under APB_REGS_WAIT_EN
module apb_regs #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      regs [NUM_REGS];

  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel;
  logic             in_range;
  logic             access;
  logic             ready;
  logic             setup_seen;
  logic             commit;
  logic             unused_addr_lsbs;

  // Word index from the byte address; the byte offset within a word is ignored
  assign idx              = PADDR[ADDR_W-1:2];
  assign sel              = idx[SEL_W-1:0];
  assign in_range         = ({1'b0, idx} < (IDX_W + 1)'(NUM_REGS));
  assign unused_addr_lsbs = ^PADDR[1:0];

  assign access     = PSEL & PENABLE;
  assign setup_seen = PSEL & ~PENABLE;

`ifdef APB_REGS_WAIT_EN
  logic [3:0] wait_cnt;

  // Wait counter: loaded at every setup phase, counts down through the access phase,
  // cleared whenever the slave is deselected (idle or aborted transfer)
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 4'd0;
    end else if (!PSEL) begin
      wait_cnt <= 4'd0;
    end else if (!PENABLE) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Completion only once the wait counter has drained; forced low while in reset
  assign ready = PRESETn & access & (wait_cnt == 4'd0);
`else
  // Zero-wait build: every access phase completes in its first cycle
  assign ready = PRESETn & access;
`endif

  assign commit = ready & PWRITE & in_range;

  assign PREADY  = ready;
  assign PSLVERR = ready & ~in_range;

  // Read data is only presented on a completing in-range read; zero otherwise
  always_comb begin
    PRDATA = 32'h0;
    if (ready && !PWRITE && in_range) begin
      PRDATA = regs[sel];
    end
  end

  // Transfer phase tracker; deselect during a transfer is an abort back to IDLE
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (setup_seen) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (setup_seen) begin
            state <= SETUP;
          end else if (ready) begin
            state <= IDLE;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (setup_seen) begin
            state <= SETUP;
          end else if (ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register array: byte-strobed writes on the completing cycle of an in-range write
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= 32'h0;
      end
    end else if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (PSTRB[k]) begin
          regs[sel][8*k +: 8] <= PWDATA[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regs.sv
// tb/tb_apb_regs.sv - directed scoreboard bench for apb_regs (either APB_REGS_WAIT_EN build)
`timescale 1ns/1ps
module tb_apb_regs;

`ifdef APB_REGS_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb_regs #(.NUM_REGS(4), .ADDR_W(12), .WAIT_CYCLES(2)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        slverr;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [4];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer starting just after a rising edge; expectation pushed at drive time
  task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    exp_t got;
    int   ridx;
    bit   oor;
    int   waits;
    bit   done;
    ridx     = int'(addr[11:2]);
    oor      = (ridx >= 4);
    e.tag    = tag;
    e.slverr = oor;
    e.waits  = EXP_WAITS;
    e.rdata  = (!wr && !oor) ? model[ridx] : 32'h0;
    sb.push_back(e);
    if (wr && !oor) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) model[ridx][8*k +: 8] = data[8*k +: 8];
      end
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge PCLK);
    check({tag, "/setup_pready"}, 32'(PREADY), 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else waits++;
    end
    got = sb.pop_front();
    check({got.tag, "/completed"}, 32'(done), 32'h1);
    if (done) begin
      check({got.tag, "/prdata"}, PRDATA, got.rdata);
      check({got.tag, "/pslverr"}, 32'(PSLVERR), 32'(got.slverr));
      check({got.tag, "/waits"}, 32'(waits), 32'(got.waits));
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) model[r] = 32'h0;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 12'h0; PWDATA = 32'h0; PSTRB = 4'h0;
    #2;
    check("reset/pready", 32'(PREADY), 32'h0);
    check("reset/prdata", PRDATA, 32'h0);
    check("reset/pslverr", 32'(PSLVERR), 32'h0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // full word write/read, then partial strobes merged over it
    xfer("wr_deadbeef", 1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
    xfer("rd_deadbeef", 1'b0, 12'h004, 32'h0, 4'h0);
    xfer("wr_strb0101", 1'b1, 12'h004, 32'h11223344, 4'b0101);
    xfer("rd_strb0101", 1'b0, 12'h004, 32'h0, 4'h0);
    check("model_strb0101", model[1], 32'hDE22BE44);

    // zero strobes leave the register alone
    xfer("wr_strb0", 1'b1, 12'h000, 32'h00000001, 4'h0);
    xfer("rd_strb0", 1'b0, 12'h000, 32'h0, 4'h0);

    // byte offset bits ignored
    xfer("wr_unaligned", 1'b1, 12'h00B, 32'hCAFEF00D, 4'hF);
    @(posedge PCLK); #1;
    xfer("rd_reg2", 1'b0, 12'h008, 32'h0, 4'h0);

    // out-of-range write and read
    xfer("wr_oor", 1'b1, 12'h010, 32'hFFFFFFFF, 4'hF);
    xfer("rd_oor", 1'b0, 12'h010, 32'h0, 4'h0);
    xfer("wr_oor_hi", 1'b1, 12'hFFC, 32'h12345678, 4'hF);
    for (int r = 0; r < 4; r++) xfer($sformatf("rd_after_oor%0d", r), 1'b0, 12'(r * 4), 32'h0, 4'h0);

    // random strobed writes, each followed back-to-back by a read of the same register
    for (int i = 0; i < 6; i++) begin
      int          r;
      logic [31:0] d;
      logic [3:0]  s;
      r = $urandom_range(0, 3);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      xfer($sformatf("rnd_wr%0d", i), 1'b1, 12'(r * 4), d, s);
      xfer($sformatf("rnd_rd%0d", i), 1'b0, 12'(r * 4), 32'h0, 4'h0);
    end

    // make reg2 nonzero, then reset in the middle of a write to it
    xfer("wr_reg2_pre", 1'b1, 12'h008, 32'h0BADF00D, 4'hF);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008;
    PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    check("midreset/pready", 32'(PREADY), 32'h0);
    check("midreset/prdata", PRDATA, 32'h0);
    check("midreset/pslverr", 32'(PSLVERR), 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int r = 0; r < 4; r++) model[r] = 32'h0;
    xfer("rd_reg2_after_reset", 1'b0, 12'h008, 32'h0, 4'h0);
    xfer("rd_reg1_after_reset", 1'b0, 12'h004, 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_regs.md
APB_REGS -- requirements
Module: apb_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of 32-bit registers, range 1..256.
REQ-002 SHALL have parameter ADDR_W, default 12: PADDR width, at least clog2(NUM_REGS)+2.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted per access when APB_REGS_WAIT_EN is defined, range 0..15.
REQ-004 SHALL have port PCLK, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port PRESETn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port PADDR, input, ADDR_W: byte address.
REQ-007 SHALL have ports PSEL, PENABLE and PWRITE, each input, 1: APB select, enable and direction.
REQ-008 SHALL have port PWDATA, input, 32: write data.
REQ-009 SHALL have port PSTRB, input, 4: write byte strobes.
REQ-010 SHALL have port PREADY, output, 1: access-phase completion.
REQ-011 SHALL have port PRDATA, output, 32: read data.
REQ-012 SHALL have port PSLVERR, output, 1: error response.

Function
REQ-013 SHALL decode register index idx = PADDR[ADDR_W-1:2] and ignore PADDR[1:0]; idx >= NUM_REGS is out-of-range.
REQ-014 SHALL implement FSM IDLE -> SETUP on PSEL&!PENABLE, SETUP -> ACCESS on the next cycle, and ACCESS -> IDLE on PREADY (or -> SETUP if PSEL&!PENABLE follows).
REQ-015 SHALL load a 4-bit wait counter with WAIT_CYCLES in SETUP and decrement it once per ACCESS cycle while it is nonzero.
REQ-016 SHALL drive PREADY combinationally high only when PSEL&PENABLE and the wait counter is 0; otherwise low.
REQ-017 SHALL commit a write only in the cycle PSEL&PENABLE&PWRITE&PREADY, updating byte k of reg[idx] from PWDATA[8k+7:8k] where PSTRB[k]=1.
REQ-018 SHALL leave a register unchanged for a write with PSTRB=4'h0, with PSLVERR=0.
REQ-019 SHALL drive PRDATA = reg[idx] when PSEL&PENABLE&!PWRITE&PREADY and idx is in range; otherwise PRDATA SHALL be 32'h0.
REQ-020 SHALL assert PSLVERR only with PREADY for an out-of-range access; such a write SHALL modify no register, and such a read SHALL return 0.
REQ-021 SHALL treat PSEL deasserted during ACCESS as abort: no commit, FSM -> IDLE, counter cleared.
REQ-022 SHALL show a write committed in cycle N in a read whose access phase completes in cycle N+1 or later, with no bypass hazard.

Reset
REQ-023 SHALL, on PRESETn low, immediately and asynchronously clear all registers to 32'h0, set the FSM to IDLE and the counter to 0, and drive PREADY=0, PRDATA=0 and PSLVERR=0.
REQ-024 SHALL, on reset during ACCESS, discard the transfer (no commit) and leave the block in IDLE after PRESETn deasserts.
REQ-025 SHALL release reset synchronously to PCLK (external synchroniser); the block accepts SETUP on the first edge after release.

Configuration
REQ-026 SHALL, with macro APB_REGS_WAIT_EN defined, insert WAIT_CYCLES wait states per access as in REQ-015/016.
REQ-027 SHALL, without APB_REGS_WAIT_EN, omit the wait counter entirely and drive PREADY = PSEL&PENABLE, giving zero wait states, with WAIT_CYCLES ignored.

Verification
REQ-028 SHALL cover a write of 32'hDEADBEEF, PSTRB=4'hF, to 0x004, then a read of 0x004 -> PRDATA=32'hDEADBEEF, PSLVERR=0.
REQ-029 SHALL cover a reg1 value of 32'hDEADBEEF, then a write of 32'h11223344 with PSTRB=4'b0101 -> read returns 32'hDE22BE44.
REQ-030 SHALL cover NUM_REGS=4 with a write to 0x010 and a read of 0x010 -> PSLVERR=1 with PREADY for both, PRDATA=0, regs 0..3 unchanged.
REQ-031 SHALL cover APB_REGS_WAIT_EN with WAIT_CYCLES=2 -> PREADY low for 2 ACCESS cycles and high on the 3rd; without the macro, PREADY is high on the 1st ACCESS cycle.
REQ-032 SHALL cover PRESETn pulsed low mid-ACCESS of a write of 32'hA5A5A5A5 to reg2 -> outputs 0 immediately and a later read of reg2 returns 32'h0.
REQ-033 SHALL cover a write to reg0 of 32'h1 with PSTRB=4'h0 -> reg0 remains 32'h0, PSLVERR=0.
